// File: rtl/codec_cfg_seq_if.sv
// rtl/codec_cfg_seq_if.sv - I2C transfer handshake between codec config sequencer and I2C master
//
// Signals:
//   go       request a transfer of i2c_data (sequencer -> I2C master)
//   i2c_data {dev_addr, reg_addr[6:0], reg_val[8:0]} (sequencer -> I2C master)
//   i2c_end  transfer-complete pulse (I2C master -> sequencer)
//   nack     acknowledge failure, valid with i2c_end (I2C master -> sequencer)
// Modports: master = sequencer side, slave = I2C master side.
interface codec_cfg_seq_if;
  logic        go;
  logic [23:0] i2c_data;
  logic        i2c_end;
  logic        nack;

  modport master (output go, output i2c_data, input i2c_end, input nack);
  modport slave  (input go, input i2c_data, output i2c_end, output nack);
endinterface

// File: rtl/codec_cfg_seq.sv
// rtl/codec_cfg_seq.sv - audio codec register initialisation sequencer over an I2C master
//
// Walks an 11-entry register table, requesting one I2C write per entry,
// re-sending on NACK up to MAX_RETRY times and enforcing an idle gap of
// SETTLE_CYCLES between transfers. Starts automatically after reset.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start_i  one-cycle re-initialise request (honoured only in DONE/FAIL)
//   i2c_if   master modport: go, i2c_data out; i2c_end, nack in
//   idx_o    current table index 0..10
//   busy_o   configuration in progress
//   act_o    codec configured and active
//   err_o    sticky configuration failure
module codec_cfg_seq #(
  parameter logic [7:0] DEV_ADDR      = 8'h34,
  parameter int         MAX_RETRY     = 3,
  parameter int         SETTLE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  codec_cfg_seq_if.master        i2c_if,
  output logic [3:0]             idx_o,
  output logic                   busy_o,
  output logic                   act_o,
  output logic                   err_o
);

  // Counter must hold MAX_RETRY+1, the value that trips the failure.
  localparam int         RETRY_W     = $clog2(MAX_RETRY + 2);
  localparam logic [3:0] LAST_IDX    = 4'd10;
  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_SETTLE, S_DONE, S_FAIL
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [7:0]           settle_q, settle_d;
  logic [23:0]          data_q, data_d;

  // Low 16 bits of each entry: {reg_addr[6:0], reg_val[8:0]}.
  function automatic logic [15:0] table_word(input logic [3:0] i);
    case (i)
      4'd0:    table_word = 16'h1E00;
      4'd1:    table_word = 16'h0017;
      4'd2:    table_word = 16'h0217;
      4'd3:    table_word = 16'h0479;
      4'd4:    table_word = 16'h0679;
      4'd5:    table_word = 16'h0812;
      4'd6:    table_word = 16'h0A06;
      4'd7:    table_word = 16'h0C00;
      4'd8:    table_word = 16'h0E02;
      4'd9:    table_word = 16'h1000;
      4'd10:   table_word = 16'h1201;
      default: table_word = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      retry_q  <= '0;
      settle_q <= 8'd0;
      data_q   <= 24'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      settle_q <= settle_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    settle_d = settle_q;
    data_d   = data_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
        idx_d   = 4'd0;
        retry_d = '0;
      end
      S_LOAD: begin
        data_d  = {DEV_ADDR, table_word(idx_q)};
        state_d = S_SEND;
      end
      S_SEND: begin
        if (i2c_if.i2c_end) begin
          if (!i2c_if.nack) begin
            retry_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d    = idx_q + 4'd1;
              settle_d = SETTLE_INIT;
              state_d  = S_SETTLE;
            end
          end else begin
            retry_d = retry_q + 1'b1;
            // The count after this NACK exceeds MAX_RETRY when it already equals it.
            if (int'(retry_q) >= MAX_RETRY) begin
              state_d = S_FAIL;
            end else begin
              settle_d = SETTLE_INIT;
              state_d  = S_SETTLE;
            end
          end
        end
      end
      S_SETTLE: begin
        // A long i2c_end pulse from the previous transfer holds us here so it
        // cannot be mistaken for completion of the next one.
        if (settle_q != 8'd0) begin
          settle_d = settle_q - 8'd1;
        end else if (!i2c_if.i2c_end) begin
          state_d = S_LOAD;
        end
      end
      S_DONE, S_FAIL: begin
        if (start_i) begin
          state_d = S_LOAD;
          idx_d   = 4'd0;
          retry_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the state directly so reset clears them immediately.
  always_comb begin
    i2c_if.go = (state_q == S_SEND);
    busy_o    = (state_q == S_LOAD) || (state_q == S_SEND) || (state_q == S_SETTLE);
    act_o     = (state_q == S_DONE);
    err_o     = (state_q == S_FAIL);
  end

  assign i2c_if.i2c_data = data_q;
  assign idx_o           = idx_q;

endmodule
